// File: rtl/end_screen_pkg.sv
// Shared types and widths for the end-of-game screen sequencer.
package end_screen_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DELAY,
      FADE,
      HOLD
   } fade_state_t;

   localparam int LEVEL_W   = 5;
   localparam int LEVEL_MAX = 16;
   localparam int FCNT_W    = 8;

endpackage

// File: rtl/fade_scale.sv
// Scales one 4-bit colour channel by a 0..16 brightness level: floor(c*level/16).
module fade_scale
   import end_screen_pkg::*;
(
   input  logic [3:0]         colour_i,
   input  logic [LEVEL_W-1:0] level_i,
   output logic [3:0]         colour_o
);

   logic [8:0] product;
   logic       unused_bits;

   assign product     = 9'(colour_i) * 9'(level_i);
   // Peak product is 15*16 = 240, so bit 8 is always zero.
   assign colour_o    = product[7:4];
   assign unused_bits = ^{product[8], product[3:0]};

endmodule

// File: rtl/end_fade_ctrl.sv
// End-screen sequencer: black delay, frame-locked fade-in, then a blinking prompt.
module end_fade_ctrl
   import end_screen_pkg::*;
#(
   parameter int unsigned DELAY_FRAMES = 30,
   parameter int unsigned STEP_FRAMES  = 4,
   parameter int unsigned BLINK_FRAMES = 30,
   parameter logic [3:0]  PROMPT_INDEX = 4'h2,
   parameter logic [3:0]  BG_INDEX     = 4'h0
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_tick,
   input  logic       game_over,
   input  logic       display_en,
   input  logic [3:0] pix_index,
   output logic [3:0] pal_index,
   input  logic [3:0] pal_red,
   input  logic [3:0] pal_green,
   input  logic [3:0] pal_blue,
   output logic [3:0] red,
   output logic [3:0] green,
   output logic [3:0] blue,
   output logic       fade_done,
   output logic       prompt_on
);

   localparam logic [FCNT_W-1:0]  DELAY_LAST = FCNT_W'(DELAY_FRAMES - 1);
   localparam logic [FCNT_W-1:0]  STEP_LAST  = FCNT_W'(STEP_FRAMES - 1);
   localparam logic [FCNT_W-1:0]  BLINK_LAST = FCNT_W'(BLINK_FRAMES - 1);
   localparam logic [LEVEL_W-1:0] LEVEL_LAST = LEVEL_W'(LEVEL_MAX - 1);

   fade_state_t        state_q, state_d;
   logic [LEVEL_W-1:0] level_q, level_d;
   logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
   logic               prompt_q, prompt_d;
   logic               done_q, done_d;
   logic [3:0]         pal_ch [3];
   logic [3:0]         scaled_ch [3];
   logic [3:0]         rgb_q [3];
   logic [3:0]         rgb_d [3];

   always_comb begin
      state_d  = state_q;
      level_d  = level_q;
      fcnt_d   = fcnt_q;
      prompt_d = prompt_q;
      unique case (state_q)
         IDLE: begin
            level_d  = '0;
            fcnt_d   = '0;
            prompt_d = 1'b0;
            if (game_over) state_d = DELAY;
         end
         DELAY: begin
            if (frame_tick) begin
               if (fcnt_q == DELAY_LAST) begin
                  state_d = FADE;
                  fcnt_d  = '0;
               end else begin
                  fcnt_d = fcnt_q + 1'b1;
               end
            end
         end
         FADE: begin
            if (frame_tick) begin
               if (fcnt_q == STEP_LAST) begin
                  level_d = level_q + 1'b1;
                  fcnt_d  = '0;
                  if (level_q == LEVEL_LAST) begin
                     state_d  = HOLD;
                     prompt_d = 1'b1;
                  end
               end else begin
                  fcnt_d = fcnt_q + 1'b1;
               end
            end
         end
         HOLD: begin
            if (frame_tick) begin
               if (fcnt_q == BLINK_LAST) begin
                  prompt_d = ~prompt_q;
                  fcnt_d   = '0;
               end else begin
                  fcnt_d = fcnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // Leaving the end screen beats any frame tick in the same cycle.
      if (state_q != IDLE && !game_over) begin
         state_d  = IDLE;
         level_d  = '0;
         fcnt_d   = '0;
         prompt_d = 1'b0;
      end
      done_d = (state_d == HOLD);
   end

   assign pal_index = (!prompt_q && pix_index == PROMPT_INDEX) ? BG_INDEX : pix_index;

   assign pal_ch[0] = pal_red;
   assign pal_ch[1] = pal_green;
   assign pal_ch[2] = pal_blue;

   for (genvar gi = 0; gi < 3; gi++) begin : g_ch
      fade_scale u_scale (
         .colour_i (pal_ch[gi]),
         .level_i  (level_q),
         .colour_o (scaled_ch[gi])
      );
      assign rgb_d[gi] = (display_en && state_q != IDLE) ? scaled_ch[gi] : 4'h0;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q  <= IDLE;
         level_q  <= '0;
         fcnt_q   <= '0;
         prompt_q <= 1'b0;
         done_q   <= 1'b0;
         for (int i = 0; i < 3; i++) rgb_q[i] <= 4'h0;
      end else begin
         state_q  <= state_d;
         level_q  <= level_d;
         fcnt_q   <= fcnt_d;
         prompt_q <= prompt_d;
         done_q   <= done_d;
         for (int i = 0; i < 3; i++) rgb_q[i] <= rgb_d[i];
      end
   end

   assign red       = rgb_q[0];
   assign green     = rgb_q[1];
   assign blue      = rgb_q[2];
   assign fade_done = done_q;
   assign prompt_on = prompt_q;

endmodule

// File: tb/tb_end_fade_ctrl.sv
// Scoreboard bench for end_fade_ctrl with short delay/step/blink periods.
module tb_end_fade_ctrl;

   localparam int         DLY    = 2;
   localparam int         STP    = 1;
   localparam int         BLK    = 3;
   localparam logic [3:0] PROMPT = 4'h2;
   localparam logic [3:0] BG     = 4'h0;

   logic       Clk = 1'b0;
   logic       Reset, frame_tick, game_over, display_en;
   logic [3:0] pix_index, pal_index, pal_red, pal_green, pal_blue;
   logic [3:0] red, green, blue;
   logic       fade_done, prompt_on;

   end_fade_ctrl #(
      .DELAY_FRAMES (DLY),
      .STEP_FRAMES  (STP),
      .BLINK_FRAMES (BLK),
      .PROMPT_INDEX (PROMPT),
      .BG_INDEX     (BG)
   ) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .frame_tick (frame_tick),
      .game_over  (game_over),
      .display_en (display_en),
      .pix_index  (pix_index),
      .pal_index  (pal_index),
      .pal_red    (pal_red),
      .pal_green  (pal_green),
      .pal_blue   (pal_blue),
      .red        (red),
      .green      (green),
      .blue       (blue),
      .fade_done  (fade_done),
      .prompt_on  (prompt_on)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [3:0] r, g, b;
      logic       done, prm;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   m_state = 0, m_level = 0, m_cnt = 0;
   logic m_prompt = 1'b0;

   function automatic logic [3:0] scale(input logic [3:0] c, input int lvl);
      return 4'((int'(c) * lvl) / 16);
   endfunction

   // Reference model: predicts outputs for this edge, then advances one clock.
   task automatic cycle();
      exp_t e;
      if (Reset || !display_en || m_state == 0) begin
         e.r = 4'h0; e.g = 4'h0; e.b = 4'h0;
      end else begin
         e.r = scale(pal_red, m_level);
         e.g = scale(pal_green, m_level);
         e.b = scale(pal_blue, m_level);
      end
      if (Reset || (m_state != 0 && !game_over)) begin
         m_state = 0; m_level = 0; m_cnt = 0; m_prompt = 1'b0;
      end else begin
         case (m_state)
            0: if (game_over) begin m_state = 1; m_cnt = 0; end
            1: if (frame_tick) begin
                  if (m_cnt == DLY - 1) begin m_state = 2; m_cnt = 0; end
                  else m_cnt++;
               end
            2: if (frame_tick) begin
                  if (m_cnt == STP - 1) begin
                     m_level++; m_cnt = 0;
                     if (m_level == 16) begin m_state = 3; m_prompt = 1'b1; end
                  end else m_cnt++;
               end
            3: if (frame_tick) begin
                  if (m_cnt == BLK - 1) begin m_prompt = ~m_prompt; m_cnt = 0; end
                  else m_cnt++;
               end
            default: ;
         endcase
      end
      e.done = (m_state == 3);
      e.prm  = m_prompt;
      sb.push_back(e);
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t e;
      Reset = 1'b1; game_over = 1'b1; display_en = 1'b1; pix_index = 4'h5;
      pal_red = 4'hF; pal_green = 4'h9; pal_blue = 4'h2;
      for (int c = 0; c < 2; c++) begin
         frame_tick = (c == 0);
         cycle();
         e = sb.pop_front();
         checks++;
         if ({red, green, blue, fade_done, prompt_on} !== 14'h0 ||
             {red, green, blue, fade_done, prompt_on} !== {e.r, e.g, e.b, e.done, e.prm}) begin
            errors++;
            $display("FAIL reset c=%0d: got rgb=%h%h%h done=%b prompt=%b, expected all zero",
                     c, red, green, blue, fade_done, prompt_on);
         end
      end
      Reset = 1'b0; game_over = 1'b0; frame_tick = 1'b1;
      cycle();
      e = sb.pop_front();
      checks++;
      if ({red, green, blue, fade_done, prompt_on} !== 14'h0) begin
         errors++;
         $display("FAIL reset_idle: got rgb=%h%h%h done=%b prompt=%b, expected all zero",
                  red, green, blue, fade_done, prompt_on);
      end
      frame_tick = 1'b0;
      $display("test_reset done");
   endtask

   task automatic test_fade_timing();
      exp_t e;
      game_over = 1'b1;
      cycle();
      e = sb.pop_front();
      checks++;
      if ({red, green, blue, fade_done} !== 13'h0) begin
         errors++;
         $display("FAIL fade_start: got rgb=%h%h%h done=%b, expected 000 0", red, green, blue, fade_done);
      end
      for (int k = 1; k <= DLY + 16; k++) begin
         for (int c = 0; c < 3; c++) begin
            frame_tick = (c == 0);
            cycle();
            e = sb.pop_front();
            checks++;
            if ({red, green, blue, fade_done, prompt_on} !== {e.r, e.g, e.b, e.done, e.prm}) begin
               errors++;
               $display("FAIL fade_sb k=%0d c=%0d: got %h%h%h d%b p%b, expected %h%h%h d%b p%b",
                        k, c, red, green, blue, fade_done, prompt_on, e.r, e.g, e.b, e.done, e.prm);
            end
            if (c == 0) begin
               checks++;
               if (fade_done !== (k >= DLY + 16)) begin
                  errors++;
                  $display("FAIL fade_done_edge tick=%0d: got %b, expected %b", k, fade_done, k >= DLY + 16);
               end
            end
            if (c == 1 && (k <= DLY + 1 || k == DLY + 8 || k == DLY + 16)) begin
               logic [11:0] want;
               want = (k == DLY + 8) ? 12'h741 : (k == DLY + 16) ? 12'hF92 : 12'h000;
               checks++;
               if ({red, green, blue} !== want) begin
                  errors++;
                  $display("FAIL fade_level tick=%0d: got %h%h%h, expected %h", k, red, green, blue, want);
               end
            end
         end
      end
      $display("test_fade_timing done");
   endtask

   task automatic test_blink();
      exp_t e;
      pix_index = PROMPT;
      #1;
      checks++;
      if (pal_index !== PROMPT) begin
         errors++;
         $display("FAIL blink_entry: got pal_index=%h, expected %h", pal_index, PROMPT);
      end
      for (int j = 1; j <= 4 * BLK; j++) begin
         for (int c = 0; c < 3; c++) begin
            frame_tick = (c == 0);
            cycle();
            e = sb.pop_front();
            checks++;
            if ({red, green, blue, fade_done, prompt_on} !== {e.r, e.g, e.b, e.done, e.prm}) begin
               errors++;
               $display("FAIL blink_sb j=%0d c=%0d: got %h%h%h d%b p%b, expected %h%h%h d%b p%b",
                        j, c, red, green, blue, fade_done, prompt_on, e.r, e.g, e.b, e.done, e.prm);
            end
            if (c == 0) begin
               logic [3:0] want;
               want = (((j / BLK) % 2) == 0) ? PROMPT : BG;
               checks++;
               if (pal_index !== want) begin
                  errors++;
                  $display("FAIL blink_prompt tick=%0d: got pal_index=%h, expected %h", j, pal_index, want);
               end
               pix_index = 4'h5;
               #1;
               checks++;
               if (pal_index !== 4'h5) begin
                  errors++;
                  $display("FAIL blink_other tick=%0d: got pal_index=%h, expected 5", j, pal_index);
               end
               pix_index = PROMPT;
            end
         end
      end
      $display("test_blink done");
   endtask

   task automatic test_abort();
      exp_t e;
      pix_index = 4'h5;
      Reset = 1'b1;
      cycle();
      void'(sb.pop_front());
      Reset = 1'b0; game_over = 1'b1;
      cycle();
      void'(sb.pop_front());
      for (int k = 1; k <= DLY + 9; k++) begin
         for (int c = 0; c < 3; c++) begin
            frame_tick = (c == 0);
            cycle();
            e = sb.pop_front();
            checks++;
            if ({red, green, blue, fade_done} !== {e.r, e.g, e.b, e.done}) begin
               errors++;
               $display("FAIL abort_sb k=%0d c=%0d: got %h%h%h d%b, expected %h%h%h d%b",
                        k, c, red, green, blue, fade_done, e.r, e.g, e.b, e.done);
            end
         end
      end
      frame_tick = 1'b1; game_over = 1'b0;
      cycle();
      e = sb.pop_front();
      checks++;
      if ({red, green, blue} !== 12'h851 || {red, green, blue} !== {e.r, e.g, e.b}) begin
         errors++;
         $display("FAIL abort_level9: got %h%h%h, expected 851", red, green, blue);
      end
      frame_tick = 1'b0;
      cycle();
      e = sb.pop_front();
      checks++;
      if ({red, green, blue, fade_done, prompt_on} !== 14'h0) begin
         errors++;
         $display("FAIL abort_idle: got %h%h%h d%b p%b, expected 000 d0 p0",
                  red, green, blue, fade_done, prompt_on);
      end
      game_over = 1'b1;
      cycle();
      void'(sb.pop_front());
      for (int k = 1; k <= DLY + 2; k++) begin
         for (int c = 0; c < 3; c++) begin
            frame_tick = (c == 0);
            cycle();
            e = sb.pop_front();
            checks++;
            if ({red, green, blue, fade_done} !== {e.r, e.g, e.b, e.done}) begin
               errors++;
               $display("FAIL restart_sb k=%0d c=%0d: got %h%h%h d%b, expected %h%h%h d%b",
                        k, c, red, green, blue, fade_done, e.r, e.g, e.b, e.done);
            end
            if (c == 1 && (k <= DLY || k == DLY + 2)) begin
               logic [11:0] want;
               want = (k == DLY + 2) ? 12'h110 : 12'h000;
               checks++;
               if ({red, green, blue} !== want) begin
                  errors++;
                  $display("FAIL restart_level tick=%0d: got %h%h%h, expected %h", k, red, green, blue, want);
               end
            end
         end
      end
      $display("test_abort done");
   endtask

   task automatic test_blanking();
      exp_t e;
      for (int k = 1; k <= 14; k++) begin
         for (int c = 0; c < 3; c++) begin
            frame_tick = (c == 0);
            cycle();
            e = sb.pop_front();
            checks++;
            if ({red, green, blue, fade_done} !== {e.r, e.g, e.b, e.done}) begin
               errors++;
               $display("FAIL blank_sb k=%0d c=%0d: got %h%h%h d%b, expected %h%h%h d%b",
                        k, c, red, green, blue, fade_done, e.r, e.g, e.b, e.done);
            end
         end
      end
      pal_red = 4'hA; pal_green = 4'h9; pal_blue = 4'h9; display_en = 1'b0;
      cycle();
      e = sb.pop_front();
      checks++;
      if ({red, green, blue, fade_done} !== 13'h1 || {red, green, blue} !== {e.r, e.g, e.b}) begin
         errors++;
         $display("FAIL blank_off: got %h%h%h d%b, expected 000 d1", red, green, blue, fade_done);
      end
      display_en = 1'b1;
      cycle();
      e = sb.pop_front();
      checks++;
      if ({red, green, blue} !== 12'hA99 || {red, green, blue} !== {e.r, e.g, e.b}) begin
         errors++;
         $display("FAIL blank_on: got %h%h%h, expected A99", red, green, blue);
      end
      $display("test_blanking done");
   endtask

   initial begin
      Reset = 1'b1; frame_tick = 1'b0; game_over = 1'b0; display_en = 1'b1;
      pix_index = 4'h0; pal_red = 4'h0; pal_green = 4'h0; pal_blue = 4'h0;
      test_reset();
      test_fade_timing();
      test_blink();
      test_abort();
      test_blanking();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/end_fade_ctrl.md
Name: end_fade_ctrl

Overview:
- Sequences the end-of-game screen. It sits between the end-screen sprite ROM index stream and the end-screen palette lookup, and drives the VGA colour outputs.
- On game over, it holds black, then fades the palette output from black to full colour over a number of frames.
- After the fade, it blinks the "press key" prompt colour by remapping its palette index.
- All fade-level and blink changes happen only on frame boundaries, so no frame tears.

Parameters:
- DELAY_FRAMES, 30: frame ticks spent black after game over, before the fade starts (range 1..255).
- STEP_FRAMES, 4: frame ticks per fade-level increment (range 1..255).
- BLINK_FRAMES, 30: frame ticks per prompt on/off half-period (range 1..255).
- PROMPT_INDEX, 4'h2: palette index of the prompt text.
- BG_INDEX, 4'h0: palette index substituted for PROMPT_INDEX while the prompt is hidden.

Ports:
- Clk  in  1  system clock; the only clock.
- Reset  in  1  synchronous, active-high reset.
- frame_tick  in  1  single-cycle pulse once per frame, at vblank start.
- game_over  in  1  level; high while the end screen should be shown.
- display_en  in  1  high during the active video region.
- pix_index  in  4  palette index from the end-screen sprite ROM for the current pixel.
- pal_index  out  4  index driven to the end-screen palette (combinational).
- pal_red  in  4  palette red, combinational response to pal_index.
- pal_green  in  4  palette green, combinational response to pal_index.
- pal_blue  in  4  palette blue, combinational response to pal_index.
- red  out  4  registered, faded red.
- green  out  4  registered, faded green.
- blue  out  4  registered, faded blue.
- fade_done  out  1  registered; high in HOLD.
- prompt_on  out  1  registered; prompt currently visible.

Behaviour:
- Reset state: IDLE, level=0, frame counter=0, prompt_on=0, fade_done=0, red/green/blue=0. Reset overrides every other input.
- State machine: IDLE, DELAY, FADE, HOLD.
  - IDLE: level=0. If game_over=1 → DELAY next cycle.
  - DELAY: counts frame_tick. On the DELAY_FRAMES-th tick since entry → FADE, with the counter cleared.
  - FADE: counts frame_tick. On every STEP_FRAMES-th tick, level increments and the counter clears. When level becomes 16 (same cycle) → HOLD.
  - HOLD: level=16, fade_done=1. Blink counter counts frame_tick; on the BLINK_FRAMES-th tick, prompt_on toggles and the counter clears. prompt_on is set to 1 on entry to HOLD.
- game_over=0 in any non-IDLE state → IDLE next cycle: level=0, counters cleared, prompt_on=0, fade_done=0. This wins over a simultaneous frame_tick.
- The frame counter is cleared on every state entry. It is 8 bits wide and does not wrap within the legal parameter range.
- prompt_on=0 outside HOLD, so the prompt stays hidden during the delay and the fade.
- Index remap (combinational): pal_index = BG_INDEX when prompt_on=0 and pix_index==PROMPT_INDEX; otherwise pal_index = pix_index.
- Fade arithmetic, per channel:
  - product = c(4b) × level(5b), 9-bit unsigned; maximum is 240.
  - out = product[7:4], i.e. floor(c·level/16).
  - level=16 gives out=c exactly; level=0 gives 0.
- Output register: red/green/blue are registered one cycle after pix_index. They are 0 when display_en=0 (display_en sampled in the same cycle as pix_index) or when the state is IDLE.
- Latency: pix_index to colour is 1 Clk. A level change takes effect on the cycle after the frame_tick that causes it.

Decomposition:
- Package end_screen_pkg holds:
  - state enum fade_state_t {IDLE, DELAY, FADE, HOLD};
  - LEVEL_W=5, LEVEL_MAX=16, FCNT_W=8.
- Sub-module fade_scale: combinational 4b colour × 5b level → 4b result, instantiated three times, once per channel.
- FSM, counters, index remap and output register live in end_fade_ctrl.

Test Plan:
- Reset check: assert Reset for 2 cycles while game_over=1 and frame_tick is pulsing → RGB=0, fade_done=0, prompt_on=0, state IDLE throughout.
- Fade timing, with DELAY=2, STEP=1 and game_over held: black for the first 2 ticks, then level 1..16 over the next 16 ticks. fade_done rises on the cycle after the 18th tick.
- Arithmetic, with pal RGB forced to F,9,2:
  - level 8 → 7,4,1;
  - level 16 → F,9,2;
  - level 1 → 0,0,0.
- Blink, with BLINK=3, in HOLD, pix_index=PROMPT_INDEX:
  - pal_index=2 for 3 ticks, then 0 for 3 ticks, repeating;
  - pix_index=5 stays 5 throughout.
- Abort: drop game_over mid-FADE at level 9, coincident with frame_tick → IDLE next cycle, RGB=0. Re-raising game_over restarts the full DELAY.
- Blanking: display_en=0 in HOLD with pal RGB=A,9,9 → RGB=0,0,0 one cycle later. With display_en=1 → A,9,9.
